io_channel_ready_generator: RTL and testbench

// - Slave-side wait-state generator for the I/O channel: drives io_channel_ready low for a

---
 rtl/io_channel_ready_generator_if.sv | 26 ++
 rtl/io_channel_ready_generator.sv | 113 +++++++++++
 tb/tb_io_channel_ready_generator.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/io_channel_ready_generator_if.sv
// I/O channel command/ready bundle shared by the bus master side and the wait-state generator.
interface io_channel_ready_generator_if;
    logic cpu_clock;
    logic chip_select_n;
    logic io_read_n;
    logic io_write_n;
    logic memory_read_n;
    logic memory_write_n;
    logic address_enable_n;
    logic device_busy;
    logic io_channel_ready;
    logic wait_active;
    logic timeout_pulse;

    modport master (
        output cpu_clock, chip_select_n, io_read_n, io_write_n,
               memory_read_n, memory_write_n, address_enable_n, device_busy,
        input  io_channel_ready, wait_active, timeout_pulse
    );

    modport slave (
        input  cpu_clock, chip_select_n, io_read_n, io_write_n,
               memory_read_n, memory_write_n, address_enable_n, device_busy,
        output io_channel_ready, wait_active, timeout_pulse
    );
endinterface

// File: rtl/io_channel_ready_generator.sv
// Slave-side wait-state generator: holds io_channel_ready low for a programmed number of
// cpu_clock periods per access, with device_busy extension and a watchdog forced release.
module io_channel_ready_generator #(
    parameter int IO_WAIT_CYCLES  = 2,
    parameter int MEM_WAIT_CYCLES = 1,
    parameter int TIMEOUT_CYCLES  = 10,
    parameter int COUNT_WIDTH     = 4
) (
    input logic                          clock,
    input logic                          reset,
    io_channel_ready_generator_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [COUNT_WIDTH-1:0] IO_LOAD  = COUNT_WIDTH'(IO_WAIT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] MEM_LOAD = COUNT_WIDTH'(MEM_WAIT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] TO_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);

    logic [1:0]             r_state;
    logic                   r_prev_cpu_clock;
    logic [COUNT_WIDTH-1:0] r_wait_cnt;
    logic [COUNT_WIDTH-1:0] r_to_cnt;
    logic                   r_ready;
    logic                   r_wait_active;
    logic                   r_timeout_pulse;

    logic                   w_cpu_posedge;
    logic                   w_io_cmd;
    logic                   w_mem_cmd;
    logic                   w_active;
    logic [COUNT_WIDTH-1:0] w_load;
    logic [COUNT_WIDTH-1:0] w_wait_next;
    logic [COUNT_WIDTH-1:0] w_to_next;
    logic                   w_timeout;

    assign w_cpu_posedge = ~r_prev_cpu_clock & bus.cpu_clock;
    assign w_io_cmd      = (~bus.io_read_n | ~bus.io_write_n) & ~bus.address_enable_n;
    assign w_mem_cmd     = ~bus.memory_read_n | ~bus.memory_write_n;
    assign w_active      = ~bus.chip_select_n & (w_io_cmd | w_mem_cmd);
    assign w_load        = w_io_cmd ? IO_LOAD : MEM_LOAD;

    // Both counters saturate rather than wrap.
    assign w_wait_next = (r_wait_cnt == '0) ? '0 : r_wait_cnt - 1'b1;
    assign w_to_next   = (r_to_cnt == '1) ? r_to_cnt : r_to_cnt + 1'b1;
    assign w_timeout   = (w_to_next >= TO_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_prev_cpu_clock <= 1'b0;
            r_wait_cnt       <= '0;
            r_to_cnt         <= '0;
            r_ready          <= 1'b1;
            r_wait_active    <= 1'b0;
            r_timeout_pulse  <= 1'b0;
        end else begin
            r_prev_cpu_clock <= bus.cpu_clock;
            r_timeout_pulse  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cpu_posedge && w_active) begin
                        r_wait_cnt <= w_load;
                        r_to_cnt   <= '0;
                        if (w_load == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state       <= S_WAIT;
                            r_ready       <= 1'b0;
                            r_wait_active <= 1'b1;
                        end
                    end
                end
                S_WAIT, S_HOLD: begin
                    if (!w_active) begin
                        r_state       <= S_IDLE;
                        r_ready       <= 1'b1;
                        r_wait_active <= 1'b0;
                    end else if (w_cpu_posedge) begin
                        r_to_cnt <= w_to_next;
                        if (r_state == S_WAIT) begin
                            r_wait_cnt <= w_wait_next;
                        end
                        // Watchdog outranks normal completion on the same cpu edge.
                        if (w_timeout) begin
                            r_state         <= S_DONE;
                            r_ready         <= 1'b1;
                            r_wait_active   <= 1'b0;
                            r_timeout_pulse <= 1'b1;
                        end else if ((r_state == S_HOLD || w_wait_next == '0) && !bus.device_busy) begin
                            r_state       <= S_DONE;
                            r_ready       <= 1'b1;
                            r_wait_active <= 1'b0;
                        end else if (r_state == S_WAIT && w_wait_next == '0) begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                default: begin
                    if (!w_active) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.io_channel_ready = r_ready;
    assign bus.wait_active      = r_wait_active;
    assign bus.timeout_pulse    = r_timeout_pulse;
endmodule

// File: tb/tb_io_channel_ready_generator.sv
// Directed bench: default instance plus a MEM_WAIT_CYCLES=0 instance fed the same stimulus.
module tb_io_channel_ready_generator;
    logic clock;
    logic reset;

    io_channel_ready_generator_if bus ();
    io_channel_ready_generator_if bus0 ();

    io_channel_ready_generator dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    io_channel_ready_generator #(
        .IO_WAIT_CYCLES  (2),
        .MEM_WAIT_CYCLES (0),
        .TIMEOUT_CYCLES  (10),
        .COUNT_WIDTH     (4)
    ) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0.slave)
    );

    assign bus0.cpu_clock        = bus.cpu_clock;
    assign bus0.chip_select_n    = bus.chip_select_n;
    assign bus0.io_read_n        = bus.io_read_n;
    assign bus0.io_write_n       = bus.io_write_n;
    assign bus0.memory_read_n    = bus.memory_read_n;
    assign bus0.memory_write_n   = bus.memory_write_n;
    assign bus0.address_enable_n = bus.address_enable_n;
    assign bus0.device_busy      = bus.device_busy;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic cs_n, ior_n, iow_n, mr_n, mw_n, aen_n, busy;
        int   busy_drop;
        int   exp_low, exp_low0, exp_to, exp_to0;
    } vec_t;

    vec_t tbl [12];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   low_clks, low0_clks, to_clks, to0_clks, wa_mis;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Outputs are sampled on the falling edge; inputs change right after.
    task automatic step();
        @(negedge clock);
        if (!bus.io_channel_ready) low_clks++;
        if (!bus0.io_channel_ready) low0_clks++;
        if (bus.timeout_pulse) to_clks++;
        if (bus0.timeout_pulse) to0_clks++;
        if (bus.wait_active != !bus.io_channel_ready) wa_mis++;
    endtask

    task automatic clear_counts();
        low_clks = 0; low0_clks = 0; to_clks = 0; to0_clks = 0; wa_mis = 0;
    endtask

    task automatic go_idle();
        bus.cpu_clock = 1'b0; bus.chip_select_n = 1'b1; bus.io_read_n = 1'b1;
        bus.io_write_n = 1'b1; bus.memory_read_n = 1'b1; bus.memory_write_n = 1'b1;
        bus.address_enable_n = 1'b0; bus.device_busy = 1'b0;
    endtask

    task automatic cpu_cycle();
        bus.cpu_clock = 1'b1; step(); step();
        bus.cpu_clock = 1'b0; step(); step();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        go_idle();
        repeat (4) step();
        clear_counts();
        bus.chip_select_n = v.cs_n; bus.io_read_n = v.ior_n; bus.io_write_n = v.iow_n;
        bus.memory_read_n = v.mr_n; bus.memory_write_n = v.mw_n;
        bus.address_enable_n = v.aen_n; bus.device_busy = v.busy;
        for (int k = 0; k < 14; k++) begin
            if (k == v.busy_drop) bus.device_busy = 1'b0;
            cpu_cycle();
        end
        check($sformatf("v%0d_low_clocks", idx), low_clks, 4 * v.exp_low);
        check($sformatf("v%0d_low_clocks_mem0", idx), low0_clks, 4 * v.exp_low0);
        check($sformatf("v%0d_timeout_clocks", idx), to_clks, v.exp_to);
        check($sformatf("v%0d_timeout_clocks_mem0", idx), to0_clks, v.exp_to0);
        check($sformatf("v%0d_wait_active_tracking", idx), wa_mis, 0);
        check($sformatf("v%0d_ready_held_in_done", idx), int'(bus.io_channel_ready), 1);
        go_idle();
        step(); step();
    endtask

    initial begin
        //          cs ior iow mr mw aen busy drop  low low0 to to0
        tbl[0]  = '{0, 0, 1, 1, 1, 0, 0, 99,   2, 2, 0, 0};  // I/O read
        tbl[1]  = '{0, 1, 0, 1, 1, 0, 0, 99,   2, 2, 0, 0};  // I/O write
        tbl[2]  = '{0, 1, 1, 1, 0, 0, 0, 99,   1, 0, 0, 0};  // memory write
        tbl[3]  = '{0, 1, 1, 0, 1, 1, 0, 99,   1, 0, 0, 0};  // memory read, DMA
        tbl[4]  = '{0, 1, 0, 1, 1, 1, 0, 99,   0, 0, 0, 0};  // I/O write, DMA
        tbl[5]  = '{1, 0, 1, 1, 1, 0, 0, 99,   0, 0, 0, 0};  // not selected
        tbl[6]  = '{0, 0, 1, 0, 1, 0, 0, 99,   2, 2, 0, 0};  // I/O wins over memory
        tbl[7]  = '{0, 0, 1, 1, 1, 0, 1, 5,    5, 5, 0, 0};  // busy 3 extra periods
        tbl[8]  = '{0, 0, 1, 1, 1, 0, 1, 99,  10, 10, 1, 1}; // busy stuck -> watchdog
        tbl[9]  = '{0, 1, 1, 1, 0, 0, 1, 99,  10, 0, 1, 0};  // mem busy stuck
        tbl[10] = '{0, 1, 1, 0, 1, 0, 1, 3,    3, 0, 0, 0};  // mem busy 2 extra
        tbl[11] = '{0, 1, 1, 1, 1, 0, 0, 99,   0, 0, 0, 0};  // no command

        go_idle();
        reset = 1'b1;
        clear_counts();
        step(); step();
        check("reset_ready", int'(bus.io_channel_ready), 1);
        check("reset_wait_active", int'(bus.wait_active), 0);
        check("reset_timeout_pulse", int'(bus.timeout_pulse), 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);

        // Command withdrawn mid-WAIT.
        go_idle(); repeat (4) step(); clear_counts();
        bus.chip_select_n = 1'b0; bus.io_read_n = 1'b0;
        cpu_cycle();
        check("abort_ready_low_before", int'(bus.io_channel_ready), 0);
        bus.io_read_n = 1'b1;
        step();
        check("abort_ready", int'(bus.io_channel_ready), 1);
        check("abort_wait_active", int'(bus.wait_active), 0);
        repeat (12) cpu_cycle();
        check("abort_no_timeout", to_clks, 0);
        run_vec(20, tbl[0]);

        // Reset pulsed mid-WAIT with the command still asserted.
        go_idle(); repeat (4) step(); clear_counts();
        bus.chip_select_n = 1'b0; bus.io_read_n = 1'b0;
        cpu_cycle();
        check("rst_ready_low_before", int'(bus.io_channel_ready), 0);
        reset = 1'b1;
        step();
        check("rst_ready", int'(bus.io_channel_ready), 1);
        check("rst_wait_active", int'(bus.wait_active), 0);
        reset = 1'b0;
        go_idle();
        repeat (12) cpu_cycle();
        check("rst_no_timeout", to_clks, 0);
        run_vec(21, tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
